// File: rtl/to_upper.sv
// Single-stage pipelined ASCII case converter with per-byte flags and a
// saturating count of bytes altered by the conversion.
module to_upper #(
  parameter int unsigned CNT_W     = 16,
  parameter bit          PASS_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       ascii_in,
  input  logic [1:0]       mode,
  input  logic             cnt_clear,
  output logic             out_valid,
  output logic [7:0]       ascii_out,
  output logic             out_is_alpha,
  output logic             out_changed,
  output logic [CNT_W-1:0] conv_count
);

  logic [7:0]       eff_byte;
  logic             is_upper;
  logic             is_lower;
  logic [7:0]       mapped;
  logic             changed;

  logic             valid_q, valid_d;
  logic [7:0]       out_q, out_d;
  logic             alpha_q, alpha_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // With PASS_HIGH=0 bit 7 is stripped before classification and mapping.
  always_comb begin
    eff_byte = PASS_HIGH ? ascii_in : {1'b0, ascii_in[6:0]};
    is_upper = (eff_byte >= 8'h41) && (eff_byte <= 8'h5A);
    is_lower = (eff_byte >= 8'h61) && (eff_byte <= 8'h7A);
  end

  always_comb begin
    mapped = eff_byte;
    unique case (mode)
      2'b00: if (is_lower) mapped = eff_byte - 8'h20;
      2'b01: if (is_upper) mapped = eff_byte + 8'h20;
      2'b10: begin
        if (is_upper) begin
          mapped = eff_byte + 8'h20;
        end else if (is_lower) begin
          mapped = eff_byte - 8'h20;
        end
      end
      2'b11: mapped = eff_byte;
    endcase
    // Compared against the raw input so a stripped high byte counts as changed.
    changed = (mapped != ascii_in);
  end

  always_comb begin
    valid_d   = in_valid;
    out_d     = out_q;
    alpha_d   = alpha_q;
    changed_d = changed_q;
    cnt_d     = cnt_q;
    if (in_valid) begin
      out_d     = mapped;
      alpha_d   = is_upper | is_lower;
      changed_d = changed;
    end
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (in_valid && changed && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      out_q     <= 8'h00;
      alpha_q   <= 1'b0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      out_q     <= out_d;
      alpha_q   <= alpha_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign ascii_out    = out_q;
  assign out_is_alpha = alpha_q;
  assign out_changed  = changed_q;
  assign conv_count   = cnt_q;

endmodule

// File: tb/tb_to_upper.sv
// Scoreboard bench for to_upper: the driver queues hand-computed results, the
// monitor pops and compares whenever the main instance presents out_valid.
module tb_to_upper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] ascii_in = 8'h00;
  logic [1:0] mode = 2'b00;
  logic       cnt_clear = 1'b0;

  logic        m_valid, m_alpha, m_changed;
  logic [7:0]  m_out;
  logic [15:0] m_cnt;
  logic        s_valid, s_alpha, s_changed;
  logic [7:0]  s_out;
  logic [15:0] s_cnt;
  logic        c_valid, c_alpha, c_changed;
  logic [7:0]  c_out;
  logic [1:0]  c_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] o;
    logic       a;
    logic       c;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  to_upper #(.CNT_W(16), .PASS_HIGH(1'b1)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ascii_in(ascii_in), .mode(mode),
    .cnt_clear(cnt_clear), .out_valid(m_valid), .ascii_out(m_out), .out_is_alpha(m_alpha),
    .out_changed(m_changed), .conv_count(m_cnt)
  );

  to_upper #(.CNT_W(16), .PASS_HIGH(1'b0)) u_strip (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ascii_in(ascii_in), .mode(mode),
    .cnt_clear(cnt_clear), .out_valid(s_valid), .ascii_out(s_out), .out_is_alpha(s_alpha),
    .out_changed(s_changed), .conv_count(s_cnt)
  );

  to_upper #(.CNT_W(2), .PASS_HIGH(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ascii_in(ascii_in), .mode(mode),
    .cnt_clear(cnt_clear), .out_valid(c_valid), .ascii_out(c_out), .out_is_alpha(c_alpha),
    .out_changed(c_changed), .conv_count(c_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected out_valid", 32'(m_out), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ascii_out", 32'(m_out), 32'(e.o));
        check("out_is_alpha", 32'(m_alpha), 32'(e.a));
        check("out_changed", 32'(m_changed), 32'(e.c));
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [7:0] d, input logic [7:0] eo,
                      input logic ea, input logic ec);
    exp_t e;
    in_valid = 1'b1;
    mode     = m;
    ascii_in = d;
    e.o = eo;
    e.a = ea;
    e.c = ec;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    cnt_clear = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] sw_in  [13] = '{8'd97, 8'd122, 8'd109, 8'd65, 8'd72, 8'd71, 8'd40,
                                8'd20, 8'd48, 8'd58, 8'd123, 8'd124, 8'd127};
    logic [7:0] sw_out [13] = '{8'd65, 8'd90, 8'd77, 8'd65, 8'd72, 8'd71, 8'd40,
                                8'd20, 8'd48, 8'd58, 8'd123, 8'd124, 8'd127};
    logic [12:0] sw_alpha = 13'b1111110000000;
    logic [12:0] sw_chg   = 13'b1110000000000;
    logic [7:0] hi_in [6] = '{8'd131, 8'd146, 8'd148, 8'd183, 8'd207, 8'd235};
    logic [7:0] bnd   [6] = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h7F, 8'h00};

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(m_valid), 32'd0);
    check("reset ascii_out", 32'(m_out), 32'd0);
    check("reset out_is_alpha", 32'(m_alpha), 32'd0);
    check("reset out_changed", 32'(m_changed), 32'd0);
    check("reset conv_count", 32'(m_cnt), 32'd0);
    rst_n = 1'b1;

    send(2'b00, 8'h61, 8'h41, 1'b1, 1'b1);
    send(2'b00, 8'h62, 8'h42, 1'b1, 1'b1);
    idle();

    // Reset mid-stream with a byte presented: it must never emerge.
    in_valid = 1'b1;
    mode     = 2'b00;
    ascii_in = 8'h63;
    rst_n    = 1'b0;
    #1;
    exp_q.delete();
    check("midreset out_valid", 32'(m_valid), 32'd0);
    check("midreset ascii_out", 32'(m_out), 32'd0);
    check("midreset out_changed", 32'(m_changed), 32'd0);
    check("midreset conv_count", 32'(m_cnt), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset out_valid", 32'(m_valid), 32'd0);

    // First byte after release: out_valid exactly one cycle later.
    send(2'b00, 8'h41, 8'h41, 1'b1, 1'b0);
    check("first-byte latency", 32'(m_valid), 32'd1);

    // Upper-mode sweep, back to back.
    for (int i = 0; i < 13; i++) begin
      send(2'b00, sw_in[i], sw_out[i], sw_alpha[12-i], sw_chg[12-i]);
      check("back-to-back out_valid", 32'(m_valid), 32'd1);
    end
    idle();
    check("sweep conv_count", 32'(m_cnt), 32'd3);
    check("sweep conv_count CNT_W=2", 32'(c_cnt), 32'd3);

    // High bytes pass unchanged when PASS_HIGH=1.
    for (int i = 0; i < 6; i++) send(2'b00, hi_in[i], hi_in[i], 1'b0, 1'b0);
    send(2'b00, 8'hE1, 8'hE1, 1'b0, 1'b0);
    check("strip 0xE1 ascii_out", 32'(s_out), 32'h41);
    check("strip 0xE1 out_changed", 32'(s_changed), 32'd1);
    check("high bytes conv_count", 32'(m_cnt), 32'd3);

    // Mode mapping and boundary bytes.
    send(2'b01, 8'h41, 8'h61, 1'b1, 1'b1);
    send(2'b10, 8'h41, 8'h61, 1'b1, 1'b1);
    send(2'b10, 8'h5A, 8'h7A, 1'b1, 1'b1);
    send(2'b11, 8'h61, 8'h61, 1'b1, 1'b0);
    send(2'b10, 8'h61, 8'h41, 1'b1, 1'b1);
    send(2'b01, 8'h7A, 8'h7A, 1'b1, 1'b0);
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 6; i++) send(2'(m), bnd[i], bnd[i], 1'b0, 1'b0);
    end

    // Gap: out_valid drops, data and flags hold.
    send(2'b00, 8'h71, 8'h51, 1'b1, 1'b1);
    idle();
    check("gap out_valid", 32'(m_valid), 32'd0);
    check("gap ascii_out held", 32'(m_out), 32'h51);
    check("gap out_changed held", 32'(m_changed), 32'd1);

    // Clear wins over a simultaneous increment.
    cnt_clear = 1'b1;
    send(2'b00, 8'h7A, 8'h5A, 1'b1, 1'b1);
    check("clear conv_count", 32'(m_cnt), 32'd0);
    check("clear conv_count CNT_W=2", 32'(c_cnt), 32'd0);

    // Saturation on the 2-bit counter.
    for (int i = 0; i < 5; i++) send(2'b00, 8'h61 + 8'(i), 8'h41 + 8'(i), 1'b1, 1'b1);
    idle();
    check("saturated conv_count CNT_W=2", 32'(c_cnt), 32'd3);
    check("unsaturated conv_count", 32'(m_cnt), 32'd5);

    idle();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/to_upper.md
Name: to_upper

Overview:
Pipelined ASCII case converter with a single register stage. Each valid input byte is mapped to upper case; lower-case, toggle and pass-through modes are also selectable. Per-byte flags and a saturating count of changed bytes are provided. It sits in the character-processing path between a byte source and downstream text consumers.

Parameters:
CNT_W, 16, width of the conversion counter conv_count.
PASS_HIGH, 1, 1 = bytes 0x80-0xFF pass unchanged; 0 = bit 7 is cleared before mapping (7-bit ASCII sanitising).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  ascii_in/mode are sampled this cycle.
ascii_in  input  8  input character byte.
mode  input  2  00 upper, 01 lower, 10 toggle case, 11 pass-through.
cnt_clear  input  1  synchronous clear of conv_count.
out_valid  output  1  ascii_out and flags hold a new result.
ascii_out  output  8  converted byte.
out_is_alpha  output  1  the sampled byte was A-Z or a-z.
out_changed  output  1  ascii_out differs from the sampled ascii_in.
conv_count  output  CNT_W  number of valid bytes with out_changed=1.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). While rst_n=0: out_valid=0, ascii_out=0x00, out_is_alpha=0, out_changed=0, conv_count=0. Reset asserted mid-stream discards the in-flight byte.
- Latency is 1 cycle. in_valid=1 at edge N gives out_valid=1 with the result after edge N. in_valid=0 gives out_valid=0 at the next edge, and ascii_out and the flags hold their last values.
- There is no backpressure. Back-to-back valid inputs give back-to-back outputs at full rate.
- Classification uses the effective byte b. b = ascii_in when PASS_HIGH=1; otherwise b = {1'b0, ascii_in[6:0]}.
  - Upper: b in 0x41-0x5A ('A'-'Z').
  - Lower: b in 0x61-0x7A ('a'-'z').
  - Everything else is non-alpha.
- Mapping:
  - mode 00: lower -> b-0x20; all else b.
  - mode 01: upper -> b+0x20; all else b.
  - mode 10: upper -> b+0x20, lower -> b-0x20; all else b.
  - mode 11: b unchanged.
- Boundary bytes are never altered: 0x40 '@', 0x5B '[', 0x60 '`', 0x7B '{', 0x7F, 0x00.
- Bytes 0x80-0xFF are never case-mapped (no Latin-1 handling). With PASS_HIGH=1 they pass unchanged.
- out_changed compares ascii_out with the raw ascii_in. With PASS_HIGH=0, a high byte that is stripped to 7 bits counts as changed.
- conv_count increments by 1 on each valid byte with changed=1 and saturates at all-ones (no wrap).
- cnt_clear=1 forces conv_count to 0 at the next edge. It takes priority over a simultaneous increment.
- mode is sampled together with ascii_in. Changing mode between bytes affects only later bytes.

Test Plan:
1. Reset: assert rst_n=0 mid-stream, then release -> all outputs 0, conv_count=0. The first valid byte after release produces out_valid exactly 1 cycle later.
2. Upper mode sweep, 1 cycle after each input:
   - 97->65, 122->90, 109->77 (out_changed=1).
   - 65->65, 72->72, 71->71 (alpha, unchanged).
   - 40, 20, 48, 58, 123, 124, 127 unchanged, out_is_alpha=0.
   - conv_count=3 at the end.
3. High bytes, PASS_HIGH=1: 131, 146, 148, 183, 207, 235 -> identical outputs, out_changed=0, out_is_alpha=0. With PASS_HIGH=0: 0xE1 -> 0x41 in mode 00, out_changed=1.
4. Modes and boundaries:
   - 0x41 -> 0x61 (mode 01) and 0x61 (mode 10).
   - 0x5A -> 0x7A in mode 10.
   - 0x61 -> 0x61 in mode 11.
   - 0x40, 0x5B, 0x60, 0x7B unchanged in every mode.
5. Stream control:
   - Back-to-back valid bytes give continuous out_valid.
   - An in_valid gap gives out_valid=0 with ascii_out held.
   - cnt_clear together with a changing byte -> conv_count=0.
   - Counter saturation checked with CNT_W=2: five lower-case bytes -> 3.
